// File: rtl/sram_like_slave_if.sv
// Request/response signals of the req/addr_ok/data_ok SRAM-like bus.
// The master drives the request side. The slave drives the handshake and response side.
interface sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_slave.sv
// Responder for the SRAM-like bus. It holds an in-order queue of outstanding requests
// and answers each one after a fixed latency from a word memory with byte strobes.
// An LFSR can optionally throttle addr_ok.
module sram_like_slave #(
    parameter int          AW        = 14,
    parameter int          DEPTH     = 4,
    parameter int          LATENCY   = 1,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       resetn,
    sram_like_slave_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);

    localparam int         PW       = $clog2(DEPTH);
    localparam int         CW       = $clog2(DEPTH + 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0]   mem [0:(2**AW)-1];
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [15:0]   lfsr_reg;
    logic          lfsr_fb;

    logic          q_valid_reg [DEPTH];
    logic [3:0]    q_cnt_reg   [DEPTH];
    logic [31:0]   q_data_reg  [DEPTH];

    logic full;
    logic stall;
    logic push;
    logic pop;
    logic unused_bits;

    assign word_idx    = bus.addr[AW+1:2];
    assign rd_word     = mem[word_idx];
    assign unused_bits = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

    // A response popping this cycle does not free a slot for an accept in the same cycle.
    assign full  = (count_reg == CW'(DEPTH));
    assign stall = (STALL_EN != 0) && lfsr_reg[0];

    assign bus.addr_ok = resetn && !full && !stall;
    assign push        = bus.req && bus.addr_ok;
    assign pop         = resetn && q_valid_reg[rd_ptr_reg] && (q_cnt_reg[rd_ptr_reg] == 4'd0);
    assign bus.data_ok = pop;
    assign bus.rdata   = q_data_reg[rd_ptr_reg];
    assign outstanding = count_reg;

    // This is the right-shifting form of the taps 16,14,13,11.
    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

    always_ff @(posedge clk) begin
        if (push && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            lfsr_reg   <= LFSR_SEED;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
            lfsr_reg  <= {lfsr_fb, lfsr_reg[15:1]};
        end
    end

    // Read data is captured into the slot at acceptance. A later write to the same
    // word therefore cannot change a response that is already queued.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic slot_load;
            logic slot_drop;

            assign slot_load = push && (wr_ptr_reg == PW'(gi));
            assign slot_drop = pop && (rd_ptr_reg == PW'(gi));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    q_valid_reg[gi] <= 1'b0;
                    q_cnt_reg[gi]   <= 4'd0;
                    q_data_reg[gi]  <= 32'd0;
                end else if (slot_load) begin
                    q_valid_reg[gi] <= 1'b1;
                    q_cnt_reg[gi]   <= CNT_INIT;
                    q_data_reg[gi]  <= bus.wr ? 32'd0 : rd_word;
                end else begin
                    if (slot_drop) begin
                        q_valid_reg[gi] <= 1'b0;
                    end
                    if (q_valid_reg[gi] && (q_cnt_reg[gi] != 4'd0)) begin
                        q_cnt_reg[gi] <= q_cnt_reg[gi] - 4'd1;
                    end
                end
            end
        end
    endgenerate

endmodule
